vram_access_sched: RTL and testbench
====================================

Name: vram_access_sched

Overview:
- Time-slot scheduler that shares the single-port video RAM between the CPU bus interface and the line renderer.
- A per-line render window opens on the render_start pulse from the video timing block.
- Inside the window the renderer has priority, but the CPU is guaranteed one slot per SLOT_PERIOD cycles. Outside the window the CPU has priority.
- Read data returns one cycle after grant, matching synchronous block-RAM latency.

Parameters:
- ADDR_W, 14, VRAM address width.
- SLOT_PERIOD, 4, window slot period in cycles; slot 0 of each period is reserved for the CPU. Must be a power of two, 2..16.
- RENDER_WINDOW, 640, length of the render window in clk cycles after render_start.

Ports:
- clk  in  1  video clock (25.175 MHz).
- reset  in  1  synchronous, active-high reset.
- render_start  in  1  single-cycle pulse that opens or restarts the render window.
- cpu_req  in  1  CPU access request; held with its address/data until cpu_ack.
- cpu_wr  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU VRAM address.
- cpu_wrdata  in  8  CPU write data.
- cpu_ack  out  1  combinational; high in the cycle the CPU access is issued to VRAM.
- cpu_rdvalid  out  1  high one cycle after a granted CPU read.
- rnd_req  in  1  renderer read request; held with its address until rnd_ack.
- rnd_addr  in  ADDR_W  renderer VRAM address.
- rnd_ack  out  1  combinational; high in the cycle the renderer read is issued.
- rnd_rdvalid  out  1  high one cycle after a granted renderer read.
- rddata  out  8  vram_rddata passthrough; meaningful only when cpu_rdvalid or rnd_rdvalid is high.
- render_busy  out  1  render window open.
- rnd_overrun  out  1  one-cycle pulse when the window closes while rnd_req is high.
- vram_addr  out  ADDR_W  VRAM address (combinational from the granted requester; 0 when idle).
- vram_wrdata  out  8  equals cpu_wrdata.
- vram_we  out  1  cpu_ack && cpu_wr.
- vram_rddata  in  8  VRAM read data, valid one cycle after the address.

Behaviour:
- Reset values: render_busy=0, window counter=0, slot counter=0, cpu_rdvalid=0, rnd_rdvalid=0, rnd_overrun=0. With no requests, acks and vram_we are 0 and vram_addr is 0.
- Window state (one register, render_busy):
  - render_start at edge T sets render_busy=1 and loads the counter with RENDER_WINDOW-1 from cycle T+1 on.
  - While busy, the counter decrements each cycle. In the cycle the counter is 0 and render_start is low, render_busy clears at the next edge.
  - The window is therefore exactly RENDER_WINDOW cycles long.
  - render_start while busy reloads the counter and clears the slot counter, so the window restarts.
- Slot counter:
  - log2(SLOT_PERIOD) bits, zeroed on render_start, incremented every cycle while render_busy, wrapping modulo SLOT_PERIOD.
  - Held at 0 while idle, so the first window cycle is a CPU slot.
- Grant (combinational, at most one per cycle):
  - In window, slot==0: cpu_req wins, else rnd_req.
  - In window, slot!=0: rnd_req wins, else cpu_req (idle slots go to the CPU).
  - Out of window: cpu_req wins, else rnd_req.
- Back-to-back grants to the same requester are allowed. A requester whose req stays high after ack issues a new access with its current address.
- Read data path:
  - cpu_rdvalid <= cpu_ack && !cpu_wr; rnd_rdvalid <= rnd_ack.
  - Writes never produce rdvalid.
  - cpu_rdvalid and rnd_rdvalid are never high together.
- rnd_overrun: registered pulse, high when the busy 1→0 transition occurs with rnd_req high in the counter==0 cycle.
- Reset mid-window: at the reset edge the window closes, the slot counter clears, rdvalid pulses drop, and an in-flight read's valid is discarded.
- render_start and reset together: reset wins.

Test Plan:
- Reset, then cpu_req read at addr 0x1234 with no window → cpu_ack in the same cycle; vram_addr=0x1234; cpu_rdvalid next cycle; rddata equals the RAM model contents.
- render_start, then rnd_req and cpu_req both held high for 16 cycles, SLOT_PERIOD=4 → CPU acked on window cycles 0,4,8,12 and renderer on the other 12 cycles; never both acked in one cycle.
- In window, rnd_req low, cpu_req write 0x55 to 0x0100 in slot 2 → immediate cpu_ack; vram_we=1; no rdvalid.
- RENDER_WINDOW=640: render_start at cycle 0 → render_busy high for cycles 1..640. With rnd_req high through cycle 640 → rnd_overrun pulse at cycle 641.
- Second render_start at window cycle 300 → busy stays high for 640 cycles after the new pulse; slot counter restarts at 0 (CPU slot).
- Reset asserted mid-window with a read granted the previous cycle → busy=0 and no rdvalid after the reset edge; the next CPU request is served immediately.

Source files
------------

// File: rtl/vram_access_sched_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vram_access_sched_if
// Purpose  : Bundles the CPU, renderer, video-timing and VRAM-side signals of
//            the VRAM access scheduler.
// Ports    : slave  - scheduler side (takes requests, drives acks/VRAM bus)
//            master - environment side (CPU, renderer, timing, VRAM model)
// Revision : 1.0 - initial release
// ============================================================================
interface vram_access_sched_if #(
  parameter int ADDR_W = 14
);
  logic              render_start;
  logic              cpu_req;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wrdata;
  logic              cpu_ack;
  logic              cpu_rdvalid;
  logic              rnd_req;
  logic [ADDR_W-1:0] rnd_addr;
  logic              rnd_ack;
  logic              rnd_rdvalid;
  logic [7:0]        rddata;
  logic              render_busy;
  logic              rnd_overrun;
  logic [ADDR_W-1:0] vram_addr;
  logic [7:0]        vram_wrdata;
  logic              vram_we;
  logic [7:0]        vram_rddata;

  modport slave (
    input  render_start, cpu_req, cpu_wr, cpu_addr, cpu_wrdata,
           rnd_req, rnd_addr, vram_rddata,
    output cpu_ack, cpu_rdvalid, rnd_ack, rnd_rdvalid, rddata,
           render_busy, rnd_overrun, vram_addr, vram_wrdata, vram_we
  );

  modport master (
    output render_start, cpu_req, cpu_wr, cpu_addr, cpu_wrdata,
           rnd_req, rnd_addr, vram_rddata,
    input  cpu_ack, cpu_rdvalid, rnd_ack, rnd_rdvalid, rddata,
           render_busy, rnd_overrun, vram_addr, vram_wrdata, vram_we
  );
endinterface
`default_nettype wire

// File: rtl/vram_access_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vram_access_sched
// Purpose  : Time-slot arbiter sharing a single-port VRAM between the CPU and
//            the line renderer. Inside the render window the renderer has
//            priority except on slot 0 of every SLOT_PERIOD cycles, which is
//            reserved for the CPU; outside the window the CPU has priority.
// Ports    : clk   - video clock
//            reset - synchronous active-high reset
//            bus   - vram_access_sched_if.slave (requests, acks, VRAM bus,
//                    window status)
// Revision : 1.0 - initial release
// ============================================================================
module vram_access_sched #(
  parameter int ADDR_W        = 14,
  parameter int SLOT_PERIOD   = 4,
  parameter int RENDER_WINDOW = 640
) (
  input  logic                     clk,
  input  logic                     reset,
  vram_access_sched_if.slave       bus
);

  localparam int               SLOT_W   = $clog2(SLOT_PERIOD);
  localparam int               CNT_W    = $clog2(RENDER_WINDOW + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RENDER_WINDOW - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } win_state_t;

  win_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              cpu_rdvalid_q, cpu_rdvalid_d;
  logic              rnd_rdvalid_q, rnd_rdvalid_d;
  logic              overrun_q, overrun_d;
  logic              cpu_gnt, rnd_gnt;

  // Window / slot next-state. The slot counter is forced to 0 whenever the
  // window is idle or closing so the first cycle of any window is a CPU slot.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    slot_d    = '0;
    overrun_d = 1'b0;
    if (bus.render_start) begin
      state_d = ST_BUSY;
      cnt_d   = CNT_LOAD;
    end else if (state_q == ST_BUSY) begin
      if (cnt_q == '0) begin
        state_d   = ST_IDLE;
        overrun_d = bus.rnd_req;
      end else begin
        cnt_d  = cnt_q - CNT_W'(1);
        slot_d = slot_q + SLOT_W'(1);
      end
    end
  end

  // Single-winner grant. On renderer slots an idle renderer yields to the CPU.
  always_comb begin
    cpu_gnt = 1'b0;
    rnd_gnt = 1'b0;
    if ((state_q == ST_BUSY) && (slot_q != '0)) begin
      rnd_gnt = bus.rnd_req;
      cpu_gnt = bus.cpu_req && !bus.rnd_req;
    end else begin
      cpu_gnt = bus.cpu_req;
      rnd_gnt = bus.rnd_req && !bus.cpu_req;
    end
  end

  assign cpu_rdvalid_d = cpu_gnt && !bus.cpu_wr;
  assign rnd_rdvalid_d = rnd_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      slot_q        <= '0;
      cpu_rdvalid_q <= 1'b0;
      rnd_rdvalid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      slot_q        <= slot_d;
      cpu_rdvalid_q <= cpu_rdvalid_d;
      rnd_rdvalid_q <= rnd_rdvalid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.cpu_ack     = cpu_gnt;
  assign bus.rnd_ack     = rnd_gnt;
  assign bus.cpu_rdvalid = cpu_rdvalid_q;
  assign bus.rnd_rdvalid = rnd_rdvalid_q;
  assign bus.rddata      = bus.vram_rddata;
  assign bus.render_busy = (state_q == ST_BUSY);
  assign bus.rnd_overrun = overrun_q;
  assign bus.vram_addr   = cpu_gnt ? bus.cpu_addr :
                           rnd_gnt ? bus.rnd_addr : '0;
  assign bus.vram_wrdata = bus.cpu_wrdata;
  assign bus.vram_we     = cpu_gnt && bus.cpu_wr;

endmodule
`default_nettype wire

// File: tb/tb_vram_access_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vram_access_sched
// Purpose  : Self-checking bench for vram_access_sched: grant vectors applied
//            from a table, read data checked through a scoreboard queue, and
//            directed sequences for window length, restart and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_access_sched;

  localparam int ADDR_W        = 14;
  localparam int SLOT_PERIOD   = 4;
  localparam int RENDER_WINDOW = 640;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vram_access_sched_if #(.ADDR_W(ADDR_W)) bus();

  vram_access_sched #(
    .ADDR_W       (ADDR_W),
    .SLOT_PERIOD  (SLOT_PERIOD),
    .RENDER_WINDOW(RENDER_WINDOW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Synchronous single-port RAM model, one cycle read latency.
  logic [7:0] mem [0:(1<<ADDR_W)-1];
  logic [7:0] rd_q;
  always @(posedge clk) begin
    if (bus.vram_we) mem[bus.vram_addr] <= bus.vram_wrdata;
    rd_q <= mem[bus.vram_addr];
  end
  assign bus.vram_rddata = rd_q;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: an expected read-data record is queued for every granted
  // read and must come back exactly one cycle later from the right source.
  typedef struct {
    bit         is_cpu;
    logic [7:0] data;
    int         cyc;
  } rd_t;
  rd_t sb[$];

  always @(negedge clk) begin
    rd_t e;
    if (bus.cpu_rdvalid || bus.rnd_rdvalid) begin
      chk("rdvalid_both", 32'(bus.cpu_rdvalid && bus.rnd_rdvalid), 32'd0);
      if (sb.size() == 0) begin
        chk("rdvalid_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rd_cycle", 32'(cyc), 32'(e.cyc));
        chk("rd_source", 32'(bus.cpu_rdvalid), 32'(e.is_cpu));
        chk("rd_data", 32'(bus.rddata), 32'(e.data));
      end
    end
    if (reset) begin
      sb.delete();
    end else begin
      if (bus.cpu_ack && !bus.cpu_wr) sb.push_back('{1'b1, mem[bus.cpu_addr], cyc + 1});
      if (bus.rnd_ack) sb.push_back('{1'b0, mem[bus.rnd_addr], cyc + 1});
    end
  end

  typedef struct {
    logic        cpu_req, cpu_wr, rnd_req;
    logic [13:0] cpu_addr, rnd_addr;
    logic [7:0]  wdata;
    logic        exp_cpu, exp_rnd, exp_we;
    logic [13:0] exp_addr;
  } vec_t;

  function automatic vec_t mk(bit cr, bit cw, bit rr, int ca, int ra, int wd,
                              bit ec, bit er, bit ew);
    vec_t v;
    v.cpu_req  = cr;  v.cpu_wr = cw;  v.rnd_req = rr;
    v.cpu_addr = 14'(ca); v.rnd_addr = 14'(ra); v.wdata = 8'(wd);
    v.exp_cpu  = ec;  v.exp_rnd = er; v.exp_we = ew;
    v.exp_addr = ec ? 14'(ca) : (er ? 14'(ra) : 14'd0);
    return v;
  endfunction

  task automatic idle_inputs();
    bus.render_start = 1'b0;
    bus.cpu_req      = 1'b0;
    bus.cpu_wr       = 1'b0;
    bus.rnd_req      = 1'b0;
  endtask

  vec_t vt[22];

  initial begin
    int n, bcnt, first, last, ocnt, ocyc;

    // Window cycles 0..15 with both requesting: CPU on slot 0 only.
    for (int i = 0; i < 16; i++)
      vt[i] = mk(1, 0, 1, 'h0200 + i, 'h0800 + i, 0, (i % 4) == 0, (i % 4) != 0, 0);
    vt[16] = mk(0, 0, 1, 'h0300, 'h0810, 0,    0, 1, 0);
    vt[17] = mk(0, 0, 0, 'h0301, 'h0811, 0,    0, 0, 0);
    vt[18] = mk(1, 1, 0, 'h0100, 'h0812, 'h55, 1, 0, 1);
    vt[19] = mk(1, 0, 0, 'h0100, 'h0813, 0,    1, 0, 0);
    vt[20] = mk(1, 0, 1, 'h0302, 'h0814, 0,    1, 0, 0);
    vt[21] = mk(1, 0, 1, 'h0303, 'h0815, 0,    0, 1, 0);

    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'((i * 37) ^ (i >> 6));

    reset = 1'b1;
    idle_inputs();
    bus.cpu_addr = '0; bus.rnd_addr = '0; bus.cpu_wrdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(bus.render_busy), 32'd0);
    chk("reset_cpu_ack", 32'(bus.cpu_ack), 32'd0);
    chk("reset_rnd_ack", 32'(bus.rnd_ack), 32'd0);
    chk("reset_we", 32'(bus.vram_we), 32'd0);
    chk("reset_addr", 32'(bus.vram_addr), 32'd0);
    chk("reset_rdvalid", 32'({bus.cpu_rdvalid, bus.rnd_rdvalid, bus.rnd_overrun}), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // CPU read outside the window
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 14'h1234;
    @(negedge clk);
    chk("idle_cpu_ack", 32'(bus.cpu_ack), 32'd1);
    chk("idle_rnd_ack", 32'(bus.rnd_ack), 32'd0);
    chk("idle_vram_addr", 32'(bus.vram_addr), 32'h1234);
    @(posedge clk); #1 bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("idle_cpu_rdvalid", 32'(bus.cpu_rdvalid), 32'd1);
    chk("idle_rddata", 32'(bus.rddata), 32'(mem[14'h1234]));

    // Slot interleave and in-window write from the vector table
    @(posedge clk); #1 bus.render_start = 1'b1;
    @(posedge clk); #1 bus.render_start = 1'b0;
    for (int i = 0; i < 22; i++) begin
      bus.cpu_req  = vt[i].cpu_req;  bus.cpu_wr   = vt[i].cpu_wr;
      bus.rnd_req  = vt[i].rnd_req;  bus.cpu_addr = vt[i].cpu_addr;
      bus.rnd_addr = vt[i].rnd_addr; bus.cpu_wrdata = vt[i].wdata;
      @(negedge clk);
      chk($sformatf("vec%0d_cpu_ack", i), 32'(bus.cpu_ack), 32'(vt[i].exp_cpu));
      chk($sformatf("vec%0d_rnd_ack", i), 32'(bus.rnd_ack), 32'(vt[i].exp_rnd));
      chk($sformatf("vec%0d_we", i), 32'(bus.vram_we), 32'(vt[i].exp_we));
      chk($sformatf("vec%0d_addr", i), 32'(bus.vram_addr), 32'(vt[i].exp_addr));
      chk($sformatf("vec%0d_busy", i), 32'(bus.render_busy), 32'd1);
      if (vt[i].exp_we) chk($sformatf("vec%0d_wrdata", i), 32'(bus.vram_wrdata), 32'h55);
      @(posedge clk); #1;
    end
    idle_inputs();

    // Let the window expire (bounded)
    n = 0;
    while (bus.render_busy && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    chk("window_close_bound", 32'(n < 1000), 32'd1);

    // Window length and overrun: render_start in cycle 0
    bus.render_start = 1'b1; bus.rnd_req = 1'b1; bus.rnd_addr = 14'h0400;
    bcnt = 0; first = 0; last = 0; ocnt = 0; ocyc = 0;
    for (int k = 1; k <= 642; k++) begin
      @(posedge clk); #1;
      bus.render_start = 1'b0;
      if (k == 641) bus.rnd_req = 1'b0;
      @(negedge clk);
      if (bus.render_busy) begin
        bcnt++; if (first == 0) first = k; last = k;
      end
      if (bus.rnd_overrun) begin ocnt++; ocyc = k; end
    end
    chk("win_busy_cycles", 32'(bcnt), 32'd640);
    chk("win_first", 32'(first), 32'd1);
    chk("win_last", 32'(last), 32'd640);
    chk("overrun_cycle", 32'(ocyc), 32'd641);
    chk("overrun_count", 32'(ocnt), 32'd1);

    // Restart at window cycle 300
    @(posedge clk); #1 bus.render_start = 1'b1;
    bcnt = 0; last = 0; ocnt = 0;
    bus.cpu_addr = 14'h0500; bus.rnd_addr = 14'h0900; bus.cpu_wr = 1'b0;
    for (int k = 1; k <= 942; k++) begin
      @(posedge clk); #1;
      bus.render_start = (k == 300);
      bus.cpu_req = (k == 301) || (k == 302);
      bus.rnd_req = (k == 301) || (k == 302);
      @(negedge clk);
      if (bus.render_busy) begin bcnt++; last = k; end
      if (bus.rnd_overrun) ocnt++;
      if (k == 301) begin
        chk("restart_slot0_cpu", 32'(bus.cpu_ack), 32'd1);
        chk("restart_slot0_rnd", 32'(bus.rnd_ack), 32'd0);
      end
      if (k == 302) begin
        chk("restart_slot1_cpu", 32'(bus.cpu_ack), 32'd0);
        chk("restart_slot1_rnd", 32'(bus.rnd_ack), 32'd1);
      end
    end
    chk("restart_busy_cycles", 32'(bcnt), 32'd940);
    chk("restart_last", 32'(last), 32'd940);
    chk("restart_no_overrun", 32'(ocnt), 32'd0);
    idle_inputs();

    // render_start together with reset: reset wins
    @(posedge clk); #1 reset = 1'b1; bus.render_start = 1'b1;
    @(posedge clk); #1 reset = 1'b0; bus.render_start = 1'b0;
    @(negedge clk);
    chk("reset_beats_start", 32'(bus.render_busy), 32'd0);

    // Reset mid-window with a read in flight
    @(posedge clk); #1 bus.render_start = 1'b1;
    @(posedge clk); #1 bus.render_start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 14'h0601;
    @(posedge clk); #1;
    reset = 1'b1; bus.cpu_addr = 14'h0600;
    @(negedge clk);
    chk("prereset_busy", 32'(bus.render_busy), 32'd1);
    chk("prereset_rdvalid", 32'(bus.cpu_rdvalid), 32'd1);
    @(posedge clk); #1 reset = 1'b0; bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("postreset_busy", 32'(bus.render_busy), 32'd0);
    chk("postreset_cpu_rdvalid", 32'(bus.cpu_rdvalid), 32'd0);
    chk("postreset_rnd_rdvalid", 32'(bus.rnd_rdvalid), 32'd0);
    @(posedge clk); #1 bus.cpu_req = 1'b1; bus.cpu_addr = 14'h0700;
    @(negedge clk);
    chk("postreset_cpu_ack", 32'(bus.cpu_ack), 32'd1);
    chk("postreset_addr", 32'(bus.vram_addr), 32'h0700);
    @(posedge clk); #1 bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("postreset_rdvalid", 32'(bus.cpu_rdvalid), 32'd1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
